// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: drives the SRAM-like data bus, formats stores, extends loads.
// Define MEM_LLSC_EN to enable the LL/SC link bit; otherwise LL acts as LW and SC as SW.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        load_type,
  input  logic [3:0]        store_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_flush,
  input  logic              mem_hold,
  input  logic              llbit_clr,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] load_data,
  output logic              sc_result,
  output logic              adel,
  output logic              ades,
  output logic              mem_stall,
  output logic              llbit
);

  localparam logic [3:0] LD_LB = 4'd1, LD_LBU = 4'd2, LD_LH = 4'd3, LD_LHU = 4'd4, LD_LL = 4'd6;
  localparam logic [3:0] ST_SB = 4'd1, ST_SH = 4'd2, ST_SC = 4'd4;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  function automatic logic [31:0] ext_load(input logic [3:0] ltype, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = rd[8*off +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (ltype)
      LD_LB:   r = 32'(b);
      LD_LBU:  r = {24'd0, b};
      LD_LH:   r = 32'(h);
      LD_LHU:  r = {16'd0, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  state_t            state_q, state_d;
  logic              kill_q, kill_d, kill_now, complete, llbit_q;
  logic [DATA_W-1:0] load_q;
  logic              ld_valid, st_valid, is_ll, is_sc, misalign, sc_fail, issue;
  logic [1:0]        acc_size;
  logic [3:0]        acc_wstrb;
  logic [DATA_W-1:0] acc_wdata;
  logic              cap_wr, cap_ll;
  logic [1:0]        cap_size;
  logic [ADDR_W-1:0] cap_addr;
  logic [3:0]        cap_wstrb, cap_ltype;
  logic [DATA_W-1:0] cap_wdata;

  assign ld_valid = (load_type >= LD_LB) && (load_type <= LD_LL);
  assign st_valid = (store_type >= ST_SB) && (store_type <= ST_SC);
  assign is_ll    = (load_type == LD_LL);
  assign is_sc    = (store_type == ST_SC);

  always_comb begin
    acc_size  = 2'd0;
    acc_wstrb = 4'b0000;
    acc_wdata = store_data;
    if (ld_valid) begin
      if (load_type == LD_LB || load_type == LD_LBU)      acc_size = 2'd0;
      else if (load_type == LD_LH || load_type == LD_LHU) acc_size = 2'd1;
      else                                                acc_size = 2'd2;
    end else if (st_valid) begin
      acc_size  = 2'd2;
      acc_wstrb = 4'b1111;
      if (store_type == ST_SB) begin
        acc_size  = 2'd0;
        acc_wstrb = 4'b0001 << addr[1:0];
        acc_wdata = {4{store_data[7:0]}};
      end else if (store_type == ST_SH) begin
        acc_size  = 2'd1;
        acc_wstrb = addr[1] ? 4'b1100 : 4'b0011;
        acc_wdata = {2{store_data[15:0]}};
      end
    end
  end

  assign misalign = (ld_valid || st_valid) &&
                    (((acc_size == 2'd1) && addr[0]) || ((acc_size == 2'd2) && (addr[1:0] != 2'b00)));
  assign adel     = misalign && ld_valid;
  assign ades     = misalign && !ld_valid && st_valid;
  assign issue    = rst_n && (state_q == S_IDLE) && (ld_valid || st_valid) &&
                    !misalign && !mem_flush && !sc_fail;
  // A flush landing in the response cycle kills that response just like an earlier one
  assign kill_now = kill_q || mem_flush;

  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    complete   = 1'b0;
    data_req   = 1'b0;
    mem_stall  = 1'b0;
    load_data  = load_q;
    data_wr    = cap_wr;
    data_size  = cap_size;
    data_addr  = cap_addr;
    data_wstrb = cap_wstrb;
    data_wdata = cap_wdata;
    case (state_q)
      S_IDLE: begin
        data_wr    = st_valid && !ld_valid;
        data_size  = acc_size;
        data_addr  = addr;
        data_wstrb = acc_wstrb;
        data_wdata = acc_wdata;
        data_req   = issue;
        mem_stall  = issue;
        if (issue) state_d = data_addr_ok ? S_WAIT : S_REQ;
      end
      S_REQ: begin
        data_req  = 1'b1;
        mem_stall = 1'b1;
        if (mem_flush)    kill_d  = 1'b1;
        if (data_addr_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        mem_stall = 1'b1;
        if (data_data_ok) begin
          kill_d  = 1'b0;
          state_d = S_IDLE;
          if (!kill_now) begin
            complete  = 1'b1;
            mem_stall = 1'b0;
            load_data = ext_load(cap_ltype, cap_addr[1:0], data_rdata);
            if (mem_hold) state_d = S_DONE;
          end
        end else if (mem_flush) begin
          kill_d = 1'b1;
        end
      end
      S_DONE: begin
        if (!mem_hold || mem_flush) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      kill_q  <= 1'b0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      if (complete) load_q <= load_data;
    end
  end

  // Request fields are frozen at issue so a flushed EXE/MEM register cannot disturb the bus
  always_ff @(posedge clk) begin
    if (issue) begin
      cap_wr    <= st_valid && !ld_valid;
      cap_size  <= acc_size;
      cap_addr  <= addr;
      cap_wstrb <= acc_wstrb;
      cap_wdata <= acc_wdata;
      cap_ltype <= ld_valid ? load_type : 4'd0;
      cap_ll    <= is_ll;
    end
  end

`ifdef MEM_LLSC_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                        llbit_q <= 1'b0;
    else if (llbit_clr || mem_flush)   llbit_q <= 1'b0;
    else if (complete && cap_ll)       llbit_q <= 1'b1;
  end
  assign sc_fail   = is_sc && !ld_valid && !llbit_q;
  assign sc_result = is_sc && llbit_q;
`else
  logic unused_llsc;
  assign unused_llsc = llbit_clr ^ cap_ll;
  assign llbit_q     = 1'b0;
  assign sc_fail     = 1'b0;
  assign sc_result   = is_sc;
`endif

  assign llbit = llbit_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized accesses checked against
// a behavioural model of access decoding, store formatting, load extension and link bit.
`timescale 1ns/1ps
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  load_type = '0, store_type = '0;
  logic [31:0] addr = '0, store_data = '0;
  logic        mem_flush = 1'b0, mem_hold = 1'b0, llbit_clr = 1'b0;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, load_data;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
  logic [31:0] data_rdata = '0;
  logic        sc_result, adel, ades, mem_stall, llbit;

  int          n_vec = 0, n_fail = 0;
  logic        llbit_m = 1'b0;
  logic [31:0] last_ld = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .load_type(load_type), .store_type(store_type),
    .addr(addr), .store_data(store_data), .mem_flush(mem_flush), .mem_hold(mem_hold),
    .llbit_clr(llbit_clr), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .load_data(load_data), .sc_result(sc_result), .adel(adel), .ades(ades),
    .mem_stall(mem_stall), .llbit(llbit)
  );

  function automatic bit llsc_en();
`ifdef MEM_LLSC_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [3:0] lt, input int lane, input logic [31:0] rd);
    longint v;
    case (lt)
      4'd1, 4'd2: begin
        v = longint'((rd >> (8 * lane)) & 32'hFF);
        if (lt == 4'd1 && v >= 128) v -= 256;
      end
      4'd3, 4'd4: begin
        v = longint'((rd >> (16 * (lane / 2))) & 32'hFFFF);
        if (lt == 4'd3 && v >= 32768) v -= 65536;
      end
      default: v = longint'(rd);
    endcase
    return v[31:0];
  endfunction

  task automatic access(input logic [3:0] lt, input logic [3:0] st, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd,
                        input int da, input int dd, input int hc);
    bit          is_ld, is_st, mis, iss, sc_op;
    int          sz, lane, stalls;
    logic [3:0]  ws;
    logic [31:0] wd, exp_ld;
    is_ld = (lt >= 1 && lt <= 6);
    is_st = !is_ld && (st >= 1 && st <= 4);
    sc_op = (st == 4'd4);
    lane  = int'(a[1:0]);
    if (is_ld)      sz = (lt <= 2) ? 0 : (lt <= 4) ? 1 : 2;
    else if (is_st) sz = (st == 1) ? 0 : (st == 2) ? 1 : 2;
    else            sz = 0;
    mis = (is_ld || is_st) && ((a % (32'd1 << sz)) != 0);
    iss = (is_ld || is_st) && !mis && !(is_st && sc_op && llsc_en() && !llbit_m);
    ws = 4'h0;
    wd = sd;
    if (is_st) begin
      if (sz == 0)      begin ws = 4'(1 << lane); wd = sd[7:0] * 32'h0101_0101; end
      else if (sz == 1) begin ws = (lane >= 2) ? 4'hC : 4'h3; wd = sd[15:0] * 32'h0001_0001; end
      else              ws = 4'hF;
    end
    exp_ld = m_load(lt, lane, rd);
    stalls = 0;

    @(negedge clk);
    load_type = lt; store_type = st; addr = a; store_data = sd;
    data_addr_ok = (da == 0); data_data_ok = 1'b0; data_rdata = $urandom; mem_hold = 1'b0;
    #1;
    chk("adel", adel, is_ld && mis);
    chk("ades", ades, is_st && mis);
    chk("sc_result", sc_result, sc_op && (!llsc_en() || llbit_m));
    if (!iss) begin
      chk("noissue_req", data_req, 0);
      chk("noissue_stall", mem_stall, 0);
    end else begin
      for (int i = 0; i <= da; i++) begin
        if (i > 0) begin
          @(negedge clk);
          data_addr_ok = (i == da);
          #1;
        end
        chk("req", data_req, 1);
        chk("addr", data_addr, a);
        chk("size", data_size, sz);
        chk("wr", data_wr, is_st);
        chk("wstrb", data_wstrb, ws);
        if (is_st) chk("wdata", data_wdata, wd);
        stalls += int'(mem_stall);
      end
      for (int j = 0; j < dd; j++) begin
        @(negedge clk);
        data_addr_ok = 1'b0;
        #1;
        chk("wait_req", data_req, 0);
        stalls += int'(mem_stall);
      end
      @(negedge clk);
      data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rd; mem_hold = (hc > 0);
      #1;
      chk("stall_cycles", stalls, 1 + da + dd);
      chk("stall_drop", mem_stall, 0);
      if (is_ld) begin
        chk("load_data", load_data, exp_ld);
        last_ld = exp_ld;
        if (lt == 4'd6 && llsc_en()) llbit_m = 1'b1;
      end
      for (int k = 0; k < hc; k++) begin
        @(negedge clk);
        data_data_ok = 1'b0; data_rdata = $urandom; mem_hold = (k < hc - 1);
        #1;
        chk("hold_req", data_req, 0);
        chk("hold_stall", mem_stall, 0);
        if (is_ld) chk("hold_load", load_data, exp_ld);
      end
    end
    @(negedge clk);
    load_type = '0; store_type = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0; mem_hold = 1'b0;
    #1;
    chk("idle_req", data_req, 0);
    chk("idle_stall", mem_stall, 0);
    chk("llbit", llbit, llbit_m);
    if (is_ld && iss) chk("load_reg", load_data, exp_ld);
  endtask

  task automatic pulse_llbit_clr();
    @(negedge clk);
    llbit_clr = 1'b1;
    @(negedge clk);
    llbit_clr = 1'b0;
    if (llsc_en()) llbit_m = 1'b0;
    #1;
    chk("llbit_clr", llbit, llbit_m);
  endtask

  initial begin
    // Reset, including an access presented while reset is held
    load_type = 4'd5; addr = 32'h40;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", data_req, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_load", load_data, 0);
    chk("rst_llbit", llbit, 0);
    chk("rst_sc", sc_result, 0);
    load_type = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Byte loads, one stall cycle
    access(4'd1, 4'd0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0, 0);
    access(4'd2, 4'd0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0, 0);
    // Halfword store with a slow address handshake
    access(4'd0, 4'd2, 32'h0000_1002, 32'h0000_BEEF, 32'h0, 3, 1, 0);
    // Misaligned accesses
    access(4'd5, 4'd0, 32'h0000_1001, 32'h0, 32'h1234_5678, 0, 0, 0);
    access(4'd0, 4'd3, 32'h0000_1002, 32'h1111_2222, 32'h0, 0, 0, 0);
    // LL then SC, then SC after link clear
    access(4'd6, 4'd0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 1, 0, 0);
    access(4'd0, 4'd4, 32'h0000_0104, 32'h5555_AAAA, 32'h0, 0, 0, 0);
    pulse_llbit_clr();
    access(4'd0, 4'd4, 32'h0000_0104, 32'h5555_AAAA, 32'h0, 0, 0, 0);
    // Word load held downstream for two cycles
    access(4'd5, 4'd0, 32'h0000_2000, 32'h0, 32'h0BAD_F00D, 0, 0, 2);
    access(4'd6, 4'd0, 32'h0000_0100, 32'h0, 32'h7777_0001, 0, 0, 0);

    // Flush while the request waits for acceptance
    @(negedge clk);
    load_type = 4'd5; addr = 32'h0000_0200; data_addr_ok = 1'b0;
    #1;
    chk("fl_req0", data_req, 1);
    chk("fl_stall0", mem_stall, 1);
    @(negedge clk);
    mem_flush = 1'b1; load_type = '0; addr = 32'h0000_03FC;
    #1;
    chk("fl_req1", data_req, 1);
    chk("fl_addr1", data_addr, 32'h0000_0200);
    chk("fl_stall1", mem_stall, 1);
    llbit_m = 1'b0;
    @(negedge clk);
    mem_flush = 1'b0; data_addr_ok = 1'b1;
    #1;
    chk("fl_req2", data_req, 1);
    chk("fl_addr2", data_addr, 32'h0000_0200);
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    #1;
    chk("fl_kill_stall", mem_stall, 1);
    chk("fl_kill_load", load_data, last_ld);
    chk("fl_llbit", llbit, 0);
    @(negedge clk);
    data_data_ok = 1'b0;
    #1;
    chk("fl_after_req", data_req, 0);
    chk("fl_after_stall", mem_stall, 0);
    chk("fl_after_load", load_data, last_ld);
    access(4'd5, 4'd0, 32'h0000_0204, 32'h0, 32'h1357_9BDF, 0, 0, 0);

    // Randomized accesses
    for (int n = 0; n < 60; n++) begin
      logic [3:0] lt, st;
      if ($urandom_range(0, 1) == 1) begin
        lt = 4'($urandom_range(0, 8)); st = 4'd0;
      end else begin
        lt = 4'd0; st = 4'($urandom_range(0, 5));
      end
      if ($urandom_range(0, 9) == 0) pulse_llbit_clr();
      access(lt, st, $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
